// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl codes, datapath widths and the buffered writeback entry.
package alu_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned RES_W      = 2 * DATA_W;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned OVF_CNT_W  = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_DIV = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  zero;
        logic                  overflow;
        logic                  ovf_qual;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream ALU result bus, downstream writeback/forwarding bus and debug counter of the result stage.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned OVF_CNT_W = alu_pkg::OVF_CNT_W
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [RES_W-1:0]      in_result;
    logic                  in_zero;
    logic                  in_overflow;
    logic [3:0]            in_aluctrl;
    logic                  in_sel_high;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;
    logic                  out_zero;
    logic                  out_overflow;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [DATA_W-1:0]     fwd_data;

    logic [OVF_CNT_W-1:0]  ovf_count;

    modport master (
        output in_valid, in_result, in_zero, in_overflow, in_aluctrl, in_sel_high,
               in_rd, in_reg_write, flush, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_reg_write, out_zero,
               out_overflow, fwd_valid, fwd_rd, fwd_data, ovf_count
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_overflow, in_aluctrl, in_sel_high,
               in_rd, in_reg_write, flush, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_reg_write, out_zero,
               out_overflow, fwd_valid, fwd_rd, fwd_data, ovf_count
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Circular buffer of writeback entries; flush empties it and overrides push and pop.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = alu_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  alu_wb_entry_t wr_entry,
    output alu_wb_entry_t head_entry,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_wb_entry_t    mem_q [DEPTH];
    alu_wb_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-memory stage: selects the writeback word, buffers results and counts retired ADD/SUB overflows.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH     = alu_pkg::DEPTH,
    parameter int unsigned OVF_CNT_W = alu_pkg::OVF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    alu_result_stage_if.slave  bus
);

    alu_wb_entry_t        new_entry;
    alu_wb_entry_t        head_entry;
    alu_wb_entry_t        head_vis;
    logic                 empty;
    logic                 full;
    logic                 in_ready_c;
    logic                 push;
    logic                 pop;
    logic [OVF_CNT_W-1:0] ovf_q, ovf_d;

    assign in_ready_c = !full && !reset;
    assign push       = bus.in_valid && in_ready_c;
    assign pop        = !empty && bus.out_ready;

    // x0 is never written back or forwarded; only ADD/SUB overflows are counted.
    always_comb begin
        new_entry           = '0;
        new_entry.data      = (bus.in_aluctrl == ALU_MUL && bus.in_sel_high)
                              ? bus.in_result[RES_W-1:DATA_W]
                              : bus.in_result[DATA_W-1:0];
        new_entry.rd        = bus.in_rd;
        new_entry.reg_write = bus.in_reg_write && (bus.in_rd != '0);
        new_entry.zero      = bus.in_zero;
        new_entry.overflow  = bus.in_overflow;
        new_entry.ovf_qual  = bus.in_overflow &&
                              (bus.in_aluctrl == ALU_ADD || bus.in_aluctrl == ALU_SUB);
    end

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (bus.flush),
        .wr_entry   (new_entry),
        .head_entry (head_entry),
        .empty      (empty),
        .full       (full)
    );

    // A flushed pop does not retire its entry.
    always_comb begin
        ovf_d = ovf_q;
        if (pop && !bus.flush && head_entry.ovf_qual && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign head_vis = empty ? '0 : head_entry;

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = !empty;
    assign bus.out_data      = head_vis.data;
    assign bus.out_rd        = head_vis.rd;
    assign bus.out_reg_write = head_vis.reg_write;
    assign bus.out_zero      = head_vis.zero;
    assign bus.out_overflow  = head_vis.overflow;
    assign bus.fwd_valid     = !empty && head_vis.reg_write;
    assign bus.fwd_rd        = head_vis.rd;
    assign bus.fwd_data      = head_vis.data;
    assign bus.ovf_count     = ovf_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a 2-bit overflow counter to reach saturation quickly.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned TB_OVF_W = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_result_stage_if #(.OVF_CNT_W(TB_OVF_W)) bus ();

    alu_result_stage #(
        .DEPTH     (2),
        .OVF_CNT_W (TB_OVF_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] ctrl, input logic [127:0] res, input logic sel_high,
                          input logic [4:0] rd, input logic rw, input logic zero, input logic ovf);
        bus.in_valid     = 1'b1;
        bus.in_aluctrl   = ctrl;
        bus.in_result    = res;
        bus.in_sel_high  = sel_high;
        bus.in_rd        = rd;
        bus.in_reg_write = rw;
        bus.in_zero      = zero;
        bus.in_overflow  = ovf;
    endtask

    task automatic push1(input logic [3:0] ctrl, input logic [127:0] res, input logic sel_high,
                         input logic [4:0] rd, input logic rw, input logic zero, input logic ovf);
        set_in(ctrl, res, sel_high, rd, rw, zero, ovf);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_result    = '0;
        bus.in_zero      = 1'b0;
        bus.in_overflow  = 1'b0;
        bus.in_aluctrl   = ALU_AND;
        bus.in_sel_high  = 1'b0;
        bus.in_rd        = '0;
        bus.in_reg_write = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ovf",       64'(bus.ovf_count), 64'd0);
        chk("rst_out_data",  bus.out_data, 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // MUL high half then low half, consumer always ready.
        bus.out_ready = 1'b1;
        push1(ALU_MUL, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("mul_hi_valid", 64'(bus.out_valid), 64'd1);
        chk("mul_hi_data",  bus.out_data, 64'h1);
        chk("mul_hi_rd",    64'(bus.out_rd), 64'd5);
        chk("mul_hi_fwd_v", 64'(bus.fwd_valid), 64'd1);
        chk("mul_hi_fwd_d", bus.fwd_data, 64'h1);
        chk("mul_hi_fwd_rd", 64'(bus.fwd_rd), 64'd5);
        push1(ALU_MUL, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("mul_lo_data",  bus.out_data, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        chk("drain_valid",  64'(bus.out_valid), 64'd0);
        chk("drain_data0",  bus.out_data, 64'd0);
        chk("drain_rd0",    64'(bus.out_rd), 64'd0);

        // sel_high ignored for AND.
        push1(ALU_AND, {64'hDEAD, 64'h0F}, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("and_data", bus.out_data, 64'h0F);
        tick();

        // Back-pressure: third of three back-to-back pushes is refused.
        bus.out_ready = 1'b0;
        set_in(ALU_ADD, 128'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        chk("bp_rdy_a", 64'(bus.in_ready), 64'd1);
        tick();
        set_in(ALU_ADD, 128'h22, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("bp_rdy_b", 64'(bus.in_ready), 64'd1);
        tick();
        set_in(ALU_ADD, 128'h33, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("bp_rdy_c", 64'(bus.in_ready), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_head_a", bus.out_data, 64'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_rdy_back", 64'(bus.in_ready), 64'd1);
        chk("bp_head_b",   bus.out_data, 64'h22);
        chk("bp_head_b_rd", 64'(bus.out_rd), 64'd2);
        tick();
        chk("bp_c_dropped", 64'(bus.out_valid), 64'd0);

        // x0 destination is never written back or forwarded.
        bus.out_ready = 1'b0;
        push1(ALU_ADD, 128'h5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("x0_valid", 64'(bus.out_valid), 64'd1);
        chk("x0_rw",    64'(bus.out_reg_write), 64'd0);
        chk("x0_fwd",   64'(bus.fwd_valid), 64'd0);
        chk("x0_zero",  64'(bus.out_zero), 64'd1);
        bus.out_ready = 1'b1;
        tick();

        // Two ADD overflows and a SUB without overflow retire.
        set_in(ALU_ADD, 128'h1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ovf_flag_head", 64'(bus.out_overflow), 64'd1);
        set_in(ALU_ADD, 128'h2, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(ALU_SUB, 128'h3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_cnt_2", 64'(bus.ovf_count), 64'd2);

        // Flush beats pop and drops the incoming entry; counter keeps its value.
        bus.out_ready = 1'b0;
        push1(ALU_ADD, 128'h9, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        set_in(ALU_ADD, 128'hA, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_ovf",   64'(bus.ovf_count), 64'd2);
        tick();
        chk("fl_in_dropped", 64'(bus.out_valid), 64'd0);

        // MUL overflow is not an ADD/SUB overflow.
        push1(ALU_MUL, 128'h4, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        chk("mul_ovf_ignored", 64'(bus.ovf_count), 64'd2);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            set_in(ALU_ADD, 128'(i), 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_sat", 64'(bus.ovf_count), 64'd3);

        // Reset with two buffered entries.
        bus.out_ready = 1'b0;
        push1(ALU_ADD, 128'h1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        push1(ALU_ADD, 128'h2, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("full_valid", 64'(bus.out_valid), 64'd1);
        chk("full_rdy",   64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ovf",   64'(bus.ovf_count), 64'd0);
        chk("mid_rst_rdy",   64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("after_rst_rdy",   64'(bus.in_ready), 64'd1);
        chk("after_rst_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-memory stage directly downstream of the 64-bit ALU; consumes its 128-bit Result, Zero and Overflow plus the destination-register tag.
- Selects the 64-bit writeback word (low half, or high half for MUL), buffers up to DEPTH results behind a valid/ready handshake, and exposes the head entry for operand forwarding.
- Keeps a saturating count of retired ADD/SUB overflows for debug visibility.

Parameters:
- DATA_W, 64, writeback word width.
- RES_W, 128, ALU result width; must equal 2*DATA_W.
- REG_ADDR_W, 5, register-index width.
- DEPTH, 2, buffer entries; power of two, at least 2.
- OVF_CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  stage can accept; equals (count < DEPTH) and not reset.
- in_result  in  RES_W  ALU Result.
- in_zero  in  1  ALU Zero flag.
- in_overflow  in  1  ALU Overflow flag.
- in_aluctrl  in  4  ALUCtrl code that produced the result.
- in_sel_high  in  1  select Result[127:64]; honoured only when in_aluctrl is MUL.
- in_rd  in  REG_ADDR_W  destination register.
- in_reg_write  in  1  result must be written back.
- flush  in  1  discard all buffered and incoming results.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  selected word of head.
- out_rd  out  REG_ADDR_W  head destination.
- out_reg_write  out  1  head write enable.
- out_zero  out  1  head Zero flag.
- out_overflow  out  1  head Overflow flag.
- fwd_valid  out  1  head forwardable; equals out_valid and out_reg_write.
- fwd_rd  out  REG_ADDR_W  forwarding tag; equals out_rd.
- fwd_data  out  DATA_W  forwarding data; equals out_data.
- ovf_count  out  OVF_CNT_W  retired ADD/SUB overflow count.

Behaviour:
- Reset: count, pointers and ovf_count cleared. in_ready=0 while reset is high and 1 the cycle after. out_valid=0. All out_*/fwd_* data fields read 0 whenever out_valid=0.
- Push occurs on in_valid && in_ready. Pop occurs on out_valid && out_ready.
- Latency: a pushed entry appears on out_* the next cycle; there is no combinational bypass. in_ready depends only on registered count, never on out_ready.
- Capture rules:
  - word = (in_aluctrl==MUL && in_sel_high) ? in_result[127:64] : in_result[63:0]. in_sel_high is ignored for all other opcodes.
  - reg_write is stored as in_reg_write && (in_rd != 0), so x0 is never written or forwarded.
  - in_zero and in_overflow are stored unmodified.
  - The stored overflow-qualify bit is in_overflow && (aluctrl is ADD or SUB).
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, no push is possible (in_ready=0), even if a pop occurs that cycle. When empty, no pop is possible.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flush: synchronous, and takes priority over push and pop.
  - count and pointers go to 0 next cycle.
  - The input presented that cycle is dropped.
  - A pop in that cycle does not retire its entry, so ovf_count does not change.
  - ovf_count is not cleared by flush.
- ovf_count increments by 1 on each pop whose entry has the overflow-qualify bit set. It saturates at all-ones and is cleared only by reset.
- Reset mid-operation discards all entries. Any handshake in flight is void.

Decomposition:
- Shared package alu_pkg holds:
  - ALUCtrl constants: ALU_AND=4'b0000, ALU_DIV=4'b0001, ALU_ADD=4'b0010, ALU_MUL=4'b0011, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - Typedef alu_wb_entry_t: data, rd, reg_write, zero, overflow, ovf_qual.
- One sub-module, alu_result_fifo: DEPTH-entry circular buffer of alu_wb_entry_t with push/pop/flush and count. The top level does word selection, x0 gating and the overflow counter.

Test Plan:
- MUL, Result=128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, sel_high=1, rd=5, out_ready=1 -> next cycle out_data=64'h1, out_rd=5, fwd_valid=1. Repeat with sel_high=0 -> out_data=64'hFFFF_FFFF_FFFF_FFFE.
- AND with sel_high=1, Result upper=64'hDEAD, lower=64'h0F -> out_data=64'h0F (high half ignored).
- Back-pressure: out_ready=0, push 3 back-to-back -> first two accepted, in_ready=0 on the third cycle. Then out_ready=1 -> entries pop in order, in_ready returns to 1 the cycle after the first pop.
- Push with rd=0, reg_write=1 -> out_reg_write=0, fwd_valid=0.
- Two ADD results with overflow=1 and one SUB result with overflow=0, all popped -> ovf_count=2. Then flush with an ADD overflow entry at head and out_ready=1 -> entry discarded, ovf_count stays 2, out_valid=0 next cycle.
- Preload ovf_count near saturation (or use OVF_CNT_W=2) and pop 5 overflowing ADDs -> ovf_count holds 2'b11. Assert reset with 2 entries buffered -> out_valid=0, ovf_count=0, in_ready=0 during reset and 1 after.
